// File: rtl/alu_pkg.sv
// Shared encodings for the RV32I ALU-control decoder: ALU operation codes,
// main-decoder ALUOp classes and the two legal func7 patterns.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD     = 4'b0000,
    ALU_SUB     = 4'b0001,
    ALU_SLL     = 4'b0010,
    ALU_SLT     = 4'b0011,
    ALU_SLTU    = 4'b0100,
    ALU_XOR     = 4'b0101,
    ALU_SRL     = 4'b0110,
    ALU_SRA     = 4'b0111,
    ALU_OR      = 4'b1000,
    ALU_AND     = 4'b1001,
    ALU_PASSB   = 4'b1010,
    ALU_INVALID = 4'b1111
  } alu_op_e;

  typedef enum logic [2:0] {
    CLS_ADD    = 3'b000,
    CLS_LUI    = 3'b001,
    CLS_RTYPE  = 3'b010,
    CLS_BRANCH = 3'b011,
    CLS_RSV4   = 3'b100,
    CLS_ITYPE  = 3'b101,
    CLS_RSV6   = 3'b110,
    CLS_RSV7   = 3'b111
  } aluop_class_e;

  localparam logic [6:0] FUNC7_BASE = 7'b0000000;
  localparam logic [6:0] FUNC7_ALT  = 7'b0100000;

  // Base operation selected by func3 alone, shared by R-type and I-type.
  function automatic alu_op_e func3_op(input logic [2:0] f3);
    unique case (f3)
      3'b000:  return ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/alu_control.sv
// Combinational ALU-control decoder (ALUOp class + func3/func7 -> ALU code)
// with a registered sticky flag recording any illegal encoding since reset.
module alu_control
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] ALUOp,
  input  logic [2:0] func3,
  input  logic [6:0] func7,
  output logic [3:0] ALUOperation,
  output logic       illegal,
  output logic       illegal_seen
);

  alu_op_e w_op;
  logic    w_illegal;
  logic    w_f7_base;
  logic    w_f7_alt;
  logic    r_illegal_seen;

  assign w_f7_base = (func7 == FUNC7_BASE);
  assign w_f7_alt  = (func7 == FUNC7_ALT);

  always_comb begin
    // NOTE: w_op gets a value before the case so no path can infer a latch;
    // anything not decoded below falls through as INVALID.
    w_op = ALU_INVALID;
    unique case (aluop_class_e'(ALUOp))
      CLS_ADD: w_op = ALU_ADD;
      CLS_LUI: w_op = ALU_PASSB;
      CLS_RTYPE: begin
        unique case (func3)
          3'b000: begin
            if (w_f7_base)     w_op = ALU_ADD;
            else if (w_f7_alt) w_op = ALU_SUB;
          end
          3'b101: begin
            if (w_f7_base)     w_op = ALU_SRL;
            else if (w_f7_alt) w_op = ALU_SRA;
          end
          default: if (w_f7_base) w_op = func3_op(func3);
        endcase
      end
      CLS_BRANCH: begin
        unique case (func3[2:1])
          2'b00:   w_op = ALU_SUB;
          2'b10:   w_op = ALU_SLT;
          2'b11:   w_op = ALU_SLTU;
          default: w_op = ALU_INVALID;
        endcase
      end
      CLS_ITYPE: begin
        unique case (func3)
          3'b001: if (w_f7_base) w_op = ALU_SLL;
          3'b101: begin
            if (w_f7_base)     w_op = ALU_SRL;
            else if (w_f7_alt) w_op = ALU_SRA;
          end
          default: w_op = func3_op(func3);
        endcase
      end
      default: w_op = ALU_INVALID;
    endcase
  end

  // INVALID is only ever produced for an illegal combination.
  assign w_illegal = (w_op == ALU_INVALID);

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignment keeps the flag update race-free with
    // every other flop sampling on the same edge.
    if (!rst_n) r_illegal_seen <= 1'b0;
    else        r_illegal_seen <= r_illegal_seen | w_illegal;
  end

  assign ALUOperation = w_op;
  assign illegal      = w_illegal;
  assign illegal_seen = r_illegal_seen;

endmodule

// File: tb/tb_alu_control.sv
// Directed and exhaustive self-checking bench for alu_control.
module tb_alu_control;

  localparam logic [3:0] E_ADD = 4'b0000, E_SUB = 4'b0001, E_SLL = 4'b0010,
                         E_SLT = 4'b0011, E_SLTU = 4'b0100, E_XOR = 4'b0101,
                         E_SRL = 4'b0110, E_SRA = 4'b0111, E_OR = 4'b1000,
                         E_AND = 4'b1001, E_PASSB = 4'b1010, E_INV = 4'b1111;

  logic       clk;
  logic       rst_n;
  logic [2:0] ALUOp;
  logic [2:0] func3;
  logic [6:0] func7;
  logic [3:0] ALUOperation;
  logic       illegal;
  logic       illegal_seen;

  int errors = 0;
  int checks = 0;

  alu_control dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ALUOp        (ALUOp),
    .func3        (func3),
    .func7        (func7),
    .ALUOperation (ALUOperation),
    .illegal      (illegal),
    .illegal_seen (illegal_seen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply(input logic [2:0] op, input logic [2:0] f3, input logic [6:0] f7);
    ALUOp = op;
    func3 = f3;
    func7 = f7;
    #1;
  endtask

  task automatic apply_check(input string tag, input logic [2:0] op, input logic [2:0] f3,
                             input logic [6:0] f7, input logic [3:0] exp_op);
    apply(op, f3, f7);
    check({tag, ".op"}, ALUOperation, exp_op);
    check({tag, ".ill"}, {3'b000, illegal}, {3'b000, exp_op == E_INV});
  endtask

  // Independent reference written as a plain if-chain over the opcode table.
  function automatic void ref_model(input logic [2:0] op, input logic [2:0] f3,
                                    input logic [6:0] f7, output logic [3:0] code,
                                    output logic ill);
    logic z, a, it;
    z    = (f7 == 7'h00);
    a    = (f7 == 7'h20);
    it   = (op == 3'b101);
    code = E_INV;
    if (op == 3'b000) code = E_ADD;
    else if (op == 3'b001) code = E_PASSB;
    else if (op == 3'b011) begin
      if (f3 == 3'd0 || f3 == 3'd1)      code = E_SUB;
      else if (f3 == 3'd4 || f3 == 3'd5) code = E_SLT;
      else if (f3 == 3'd6 || f3 == 3'd7) code = E_SLTU;
    end else if (op == 3'b010 || it) begin
      if (f3 == 3'd0) begin
        if (it || z) code = E_ADD;
        else if (a)  code = E_SUB;
      end
      else if (f3 == 3'd1 && z)         code = E_SLL;
      else if (f3 == 3'd2 && (it || z)) code = E_SLT;
      else if (f3 == 3'd3 && (it || z)) code = E_SLTU;
      else if (f3 == 3'd4 && (it || z)) code = E_XOR;
      else if (f3 == 3'd5) begin
        if (z)      code = E_SRL;
        else if (a) code = E_SRA;
      end
      else if (f3 == 3'd6 && (it || z)) code = E_OR;
      else if (f3 == 3'd7 && (it || z)) code = E_AND;
    end
    ill = (code == E_INV);
  endfunction

  initial begin
    logic [3:0] m_code;
    logic       m_ill;
    logic [12:0] v;

    rst_n = 1'b0;
    ALUOp = 3'b000;
    func3 = 3'b000;
    func7 = 7'h00;
    #2;
    check("reset.seen", {3'b000, illegal_seen}, 4'h0);
    #10 rst_n = 1'b1;

    // T1
    apply_check("t1.a", 3'b000, 3'b110, 7'h00, E_ADD);
    apply_check("t1.b", 3'b000, 3'b111, 7'h00, E_ADD);
    apply_check("lui", 3'b001, 3'b011, 7'h7F, E_PASSB);
    // T2
    apply_check("t2.or",   3'b101, 3'b110, 7'h00, E_OR);
    apply_check("t2.and",  3'b101, 3'b111, 7'h00, E_AND);
    apply_check("t2.add",  3'b101, 3'b000, 7'h00, E_ADD);
    apply_check("t2.xor",  3'b101, 3'b100, 7'h00, E_XOR);
    apply_check("t2.srl",  3'b101, 3'b101, 7'h00, E_SRL);
    apply_check("t2.sltu", 3'b101, 3'b011, 7'h00, E_SLTU);
    apply_check("t2.sra",  3'b101, 3'b101, 7'h20, E_SRA);
    apply_check("t2.sllx", 3'b101, 3'b001, 7'h20, E_INV);
    // T3
    apply_check("t3.bge",  3'b011, 3'b101, 7'h00, E_SLT);
    apply_check("t3.blt",  3'b011, 3'b100, 7'h00, E_SLT);
    apply_check("t3.beq",  3'b011, 3'b000, 7'h00, E_SUB);
    apply_check("t3.bltu", 3'b011, 3'b110, 7'h00, E_SLTU);
    apply_check("t3.b010", 3'b011, 3'b010, 7'h00, E_INV);
    // T4 legal part, then confirm no illegal was latched yet
    apply_check("t4.sltu", 3'b010, 3'b011, 7'h00, E_SLTU);
    apply_check("t4.sub",  3'b010, 3'b000, 7'h20, E_SUB);
    apply_check("t4.ok",   3'b010, 3'b110, 7'h00, E_OR);
    @(negedge clk);
    check("pre.seen", {3'b000, illegal_seen}, 4'h0);
    apply_check("t4.xorx", 3'b010, 3'b100, 7'h20, E_INV);
    // T5
    apply_check("t5.rsv", 3'b111, 3'b111, 7'h7F, E_INV);
    @(posedge clk);
    #1;
    check("t5.seen", {3'b000, illegal_seen}, 4'h1);
    apply_check("t5.legal", 3'b000, 3'b000, 7'h00, E_ADD);
    repeat (3) @(posedge clk);
    #1;
    check("t5.sticky", {3'b000, illegal_seen}, 4'h1);

    // T6: asynchronous reset mid-cycle, then sweep every input with reset held
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t6.async", {3'b000, illegal_seen}, 4'h0);
    for (int i = 0; i < 8192; i++) begin
      v = 13'(i);
      apply(v[12:10], v[9:7], v[6:0]);
      ref_model(v[12:10], v[9:7], v[6:0], m_code, m_ill);
      check($sformatf("sweep.op[%0h]", v), ALUOperation, m_code);
      check($sformatf("sweep.ill[%0h]", v), {3'b000, illegal}, {3'b000, m_ill});
    end
    check("t6.held", {3'b000, illegal_seen}, 4'h0);

    @(negedge clk);
    rst_n = 1'b1;
    apply(3'b010, 3'b000, 7'h00);
    @(posedge clk);
    #1;
    check("post.seen", {3'b000, illegal_seen}, 4'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
